// File: rtl/qnigma_math_chacha20_core.sv
// ChaCha20 block core: one shared multi-cycle quarter-round unit runs 8*DR quarter
// rounds over the working state, then feed-forward sums are streamed out word by word.

module qnigma_math_chacha20_qr (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o,
    input  logic [31:0] add_a,
    input  logic [31:0] add_b,
    output logic [31:0] q
);
    logic [2:0] step;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Eight micro-steps: each add and each xor-rotate of the quarter round gets its own cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_o  <= a_i;
            b_o  <= b_i;
            c_o  <= c_i;
            d_o  <= d_i;
            step <= 3'd0;
        end else if (run) begin
            case (step)
                3'd0: a_o <= a_o + b_o;
                3'd1: d_o <= rotl(d_o ^ a_o, 16);
                3'd2: c_o <= c_o + d_o;
                3'd3: b_o <= rotl(b_o ^ c_o, 12);
                3'd4: a_o <= a_o + b_o;
                3'd5: d_o <= rotl(d_o ^ a_o, 8);
                3'd6: c_o <= c_o + d_o;
                default: b_o <= rotl(b_o ^ c_o, 7);
            endcase
            step <= step + 3'd1;
        end
    end

    assign q = add_a + add_b;
endmodule

module qnigma_math_chacha20_core #(
    parameter int DR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  counter,
    output logic         busy,
    output logic         done,
    output logic         ks_val,
    input  logic         ks_rdy,
    output logic [31:0]  ks_dat,
    output logic [3:0]   ks_idx,
    output logic         ks_last
);
    localparam int NQ = 8 * DR;
    localparam int QW = $clog2(NQ);
    localparam logic [QW-1:0] QI_LAST = QW'(NQ - 1);

    typedef enum logic [2:0] {S_IDLE, S_QLD, S_QRUN, S_QWB, S_FSUM, S_OUT} state_t;
    state_t state, state_nx;

    logic [31:0]   work [16];
    logic [31:0]   init [16];
    logic [31:0]   iv   [16];
    logic [QW-1:0] qi;
    logic [2:0]    run_cnt;
    logic [2:0]    sel;
    logic [1:0]    j;
    logic [3:0]    ia, ib, ic, id;
    logic [3:0]    add_idx;
    logic          qr_rst, qr_run;
    logic [31:0]   qa, qb, qc, qd, add_q;

    always_comb begin
        for (int i = 0; i < 16; i++) iv[i] = 32'd0;
        iv[0] = 32'h61707865;
        iv[1] = 32'h3320646e;
        iv[2] = 32'h79622d32;
        iv[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) iv[4+i] = key[32*i +: 32];
        iv[12] = counter;
        for (int i = 0; i < 3; i++) iv[13+i] = nonce[32*i +: 32];
    end

    // Columns keep the lane fixed; diagonals rotate lanes b/c/d by 1/2/3 within each row.
    assign sel = qi[2:0];
    assign j   = sel[1:0];
    always_comb begin
        ia = {2'b00, j};
        ib = {2'b01, j};
        ic = {2'b10, j};
        id = {2'b11, j};
        if (sel[2]) begin
            ib = {2'b01, j + 2'd1};
            ic = {2'b10, j + 2'd2};
            id = {2'b11, j + 2'd3};
        end
    end

    assign add_idx = (state == S_FSUM) ? 4'd0 : ks_idx + 4'd1;

    qnigma_math_chacha20_qr u_qr (
        .clk   (clk),
        .rst   (qr_rst),
        .run   (qr_run),
        .a_i   (work[ia]),
        .b_i   (work[ib]),
        .c_i   (work[ic]),
        .d_i   (work[id]),
        .a_o   (qa),
        .b_o   (qb),
        .c_o   (qc),
        .d_o   (qd),
        .add_a (work[add_idx]),
        .add_b (init[add_idx]),
        .q     (add_q)
    );

    always_comb begin
        state_nx = state;
        qr_rst   = 1'b0;
        qr_run   = 1'b0;
        case (state)
            S_IDLE: if (start) state_nx = S_QLD;
            S_QLD: begin
                qr_rst   = 1'b1;
                state_nx = S_QRUN;
            end
            S_QRUN: begin
                qr_run = 1'b1;
                if (run_cnt == 3'd7) state_nx = S_QWB;
            end
            S_QWB:  state_nx = (qi == QI_LAST) ? S_FSUM : S_QLD;
            S_FSUM: state_nx = S_OUT;
            S_OUT:  if (ks_rdy && ks_idx == 4'd15) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qi      <= '0;
            run_cnt <= 3'd0;
            ks_val  <= 1'b0;
            ks_dat  <= 32'd0;
            ks_idx  <= 4'd0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: qi <= '0;
                S_QLD:  run_cnt <= 3'd0;
                S_QRUN: run_cnt <= run_cnt + 3'd1;
                S_QWB:  qi <= (qi == QI_LAST) ? '0 : qi + 1'b1;
                S_FSUM: begin
                    ks_dat <= add_q;
                    ks_idx <= 4'd0;
                    ks_val <= 1'b1;
                end
                S_OUT: begin
                    if (ks_rdy) begin
                        if (ks_idx == 4'd15) begin
                            ks_val <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            ks_dat <= add_q;
                            ks_idx <= ks_idx + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State words carry no reset; they are reloaded in full on every accepted start.
    always_ff @(posedge clk) begin
        if (!rst && state == S_IDLE && start) begin
            for (int i = 0; i < 16; i++) begin
                work[i] <= iv[i];
                init[i] <= iv[i];
            end
        end else if (state == S_QWB) begin
            work[ia] <= qa;
            work[ib] <= qb;
            work[ic] <= qc;
            work[id] <= qd;
        end
    end

    assign busy    = (state != S_IDLE);
    assign ks_last = ks_val && (ks_idx == 4'd15);
endmodule

// File: doc/qnigma_math_chacha20_core.md
Name: qnigma_math_chacha20_core

Overview:
- Sequences one shared ChaCha20 quarter-round unit through a full 64-byte ChaCha20 block.
- Owns the 16-word working state and the initial-state copy, and schedules the column and diagonal quarter rounds.
- Performs the final feed-forward sums through the unit's two-input add port.
- Streams the 16 keystream words out over a valid/ready handshake to the AEAD/stream-cipher layer.

Parameters:
DR, 10, number of double rounds (10 = ChaCha20; 4/6 allowed for ChaCha8/12); total quarter rounds = 8*DR

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  begin one block; sampled only in IDLE
key  in  256  key; word k_i = key[32i+31:32i], i=0..7
nonce  in  96  nonce; word n_i = nonce[32i+31:32i], i=0..2
counter  in  32  block counter
busy  out  1  high from the cycle after start accepted until return to IDLE
done  out  1  one-cycle pulse when word 15 is accepted
ks_val  out  1  keystream word valid
ks_rdy  in  1  downstream ready
ks_dat  out  32  keystream word
ks_idx  out  4  index of ks_dat, 0..15
ks_last  out  1  ks_val && ks_idx==15

Behaviour:
- Reset: state IDLE; busy, done, ks_val, ks_last = 0; ks_dat, ks_idx = 0; qr counter = 0. Reset mid-operation abandons the block with no partial output; working/init registers need not be cleared.
- Initial state: w0..w3 = 61707865, 3320646e, 79622d32, 6b206574; w4..w11 = k0..k7; w12 = counter; w13..w15 = n0..n2.
- IDLE: on start, the initial state is latched into both work[] and init[] at the same edge (cycle T). Next state is QLD. start in any other state is ignored.
- Quarter-round schedule: counter qi = 0..8*DR-1; sel = qi[2:0].
  - Columns: sel 0..3 = (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15).
  - Diagonals: sel 4..7 = (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
- QLD, 1 cycle: drive unit rst=1 with a_i..d_i = the selected work words, run=0. Next state is QRUN.
- QRUN, 8 cycles: unit run=1, rst=0; a 3-bit counter counts 8. Next state is QWB.
- QWB, 1 cycle: write unit a_o..d_o back to the selected work words; qi++.
  - If qi was 8*DR-1, go to FSUM.
  - Otherwise go to QLD.
- Each quarter round takes 10 cycles; the round phase takes 80*DR cycles.
- Shared-unit rule: unit rst is driven only in QLD and run only in QRUN. In all other states both are 0, and its a/b add port carries the feed-forward operands.
- FSUM, 1 cycle: unit a=work[0], b=init[0]. Register ks_dat = q (mod 2^32), ks_idx=0, ks_val=1. Next state is OUT.
- The add port has zero latency, so q is valid in the same cycle.
- OUT:
  - ks_dat, ks_idx and ks_val hold stable while ks_val && !ks_rdy.
  - On handshake with idx<15: load ks_dat = work[idx+1]+init[idx+1] and increment idx at the same edge. Throughput is 1 word/cycle with ks_rdy held high.
  - On handshake with idx==15: ks_val=0, done=1 for one cycle, go to IDLE. busy drops at the same edge.
- Latency: start at T leads to first ks_val at T+2+10*8*DR (T+802 for DR=10). With ks_rdy held high, done pulses 16 cycles later.
- start in the same cycle as the final handshake is ignored (state is not yet IDLE).
- Widths: all arithmetic is 32-bit modulo; no carries are kept.

Test Plan:
- Unit sanity, RFC 8439 2.1.1: force QLD with a..d = 11111111, 01020304, 9b8d6f43, 01234567 -> after QWB, work holds ea2a92f4, cb1cf8ce, 4581472e, 5881c4bb.
- RFC 8439 2.3.2 vector: key words 03020100..1f1e1d1c, counter=1, nonce words 09000000, 4a000000, 00000000, ks_rdy=1 -> ks_val first at T+802, words e4e7f110, 15593bd1, 1fdd0f50, c47120a3 ... 4e3c50a2, ks_last on idx 15, done pulse 1 cycle later edge.
- Backpressure: same vector with ks_rdy toggling 1-0-0-1 pseudo-random -> identical word sequence, ks_dat/ks_idx stable while stalled, no dropped or repeated idx.
- Ignored start: pulse start at T+5, T+400 and in the final handshake cycle -> single block output, busy continuous, no restart.
- Reset mid-operation: assert rst at T+300 and at OUT idx=7 -> next cycle ks_val=0, busy=0, done=0; a fresh start then produces the full correct block.
- DR=4 build with the 2.3.2 inputs -> first ks_val at T+322; output matches the reference ChaCha8 model.
